// File: rtl/checker_pkg.sv
// Shared types for the memory result checker: sequence modes, FSM states
// and the mapping of the raw 2-bit mode input onto a supported mode.
package checker_pkg;

    typedef enum logic [1:0] {
        CHK_FIB   = 2'd0,
        CHK_ARITH = 2'd1,
        CHK_CONST = 2'd2
    } chk_mode_e;

    // Encoding 3 is not a real mode; it behaves like CONST.
    localparam logic [1:0] CHK_MODE_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_READ = 3'd2,
        ST_LAT  = 3'd3,
        ST_CMP  = 3'd4,
        ST_DONE = 3'd5
    } chk_state_e;

    function automatic chk_mode_e decode_mode(input logic [1:0] raw);
        chk_mode_e m;
        case (raw)
            2'd0:              m = CHK_FIB;
            2'd1:              m = CHK_ARITH;
            CHK_MODE_RESERVED: m = CHK_CONST;
            default:           m = CHK_CONST;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/golden_seq_gen.sv
// Golden sequence generator. cur_reg is the word expected at the current
// index; nxt_reg is the following Fibonacci term (FIB) or the step (ARITH).
// All arithmetic wraps modulo 2^DATA_W.
module golden_seq_gen
    import checker_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              load,
    input  logic              advance,
    input  chk_mode_e         mode,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    output logic [DATA_W-1:0] expected
);

    logic [DATA_W-1:0] cur_reg;
    logic [DATA_W-1:0] nxt_reg;

    // Load seeds at run start, then step the sequence once per compared word.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cur_reg <= '0;
            nxt_reg <= '0;
        end else if (load) begin
            cur_reg <= seed_a;
            nxt_reg <= seed_b;
        end else if (advance) begin
            case (mode)
                CHK_FIB: begin
                    cur_reg <= nxt_reg;
                    nxt_reg <= cur_reg + nxt_reg;
                end
                CHK_ARITH: begin
                    cur_reg <= cur_reg + nxt_reg;
                end
                default: begin
                    cur_reg <= cur_reg;
                end
            endcase
        end
    end

    assign expected = cur_reg;

endmodule

// File: rtl/mem_result_checker.sv
// Memory result checker: after start it waits a programmable time, reads
// NUM_WORDS words from a data-memory region and compares them against a
// generated golden sequence, reporting match/mismatch counts and the index
// of the first mismatch.
module mem_result_checker
    import checker_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                NUM_WORDS  = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                STRIDE     = 4,
    parameter int                RD_LATENCY = 1,
    parameter int                CNT_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    input  logic [15:0]       wait_cycles,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  ok_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              first_err_valid
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
    // Latency counter only needs to hold RD_LATENCY-1.
    localparam int               LAT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    chk_state_e        state_reg, state_next;
    chk_mode_e         mode_reg;
    logic [15:0]       wait_cnt_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  err_reg;
    logic [CNT_W-1:0]  ok_reg;
    logic [CNT_W-1:0]  fidx_reg;
    logic              fvalid_reg;

    logic              start_accept;
    logic              cmp_en;
    logic              word_match;
    logic [DATA_W-1:0] expected;

    golden_seq_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .clk      (clk),
        .areset   (areset),
        .load     (start_accept),
        .advance  (cmp_en),
        .mode     (mode_reg),
        .seed_a   (seed_a),
        .seed_b   (seed_b),
        .expected (expected)
    );

    assign word_match = (mem_rdata == expected);

    // Next-state logic; abort overrides everything outside IDLE, and start
    // is only honoured when idle or finished and not aborted in that cycle.
    always_comb begin
        state_next   = state_reg;
        start_accept = 1'b0;
        cmp_en       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next   = ST_WAIT;
                    start_accept = 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 16'd0) state_next = ST_READ;
            end
            ST_READ: begin
                state_next = (RD_LATENCY == 1) ? ST_CMP : ST_LAT;
            end
            ST_LAT: begin
                if (lat_cnt_reg <= LAT_W'(1)) state_next = ST_CMP;
            end
            ST_CMP: begin
                cmp_en     = 1'b1;
                state_next = (idx_reg == LAST_IDX) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                if (start) begin
                    state_next   = ST_WAIT;
                    start_accept = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort && (state_reg != ST_IDLE)) begin
            state_next   = ST_IDLE;
            start_accept = 1'b0;
            cmp_en       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Run setup, wait/latency timers, word index and read address.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            mode_reg     <= CHK_FIB;
            wait_cnt_reg <= '0;
            lat_cnt_reg  <= '0;
            idx_reg      <= '0;
            addr_reg     <= '0;
        end else if (start_accept) begin
            mode_reg     <= decode_mode(mode);
            wait_cnt_reg <= wait_cycles;
            lat_cnt_reg  <= '0;
            idx_reg      <= '0;
            addr_reg     <= BASE_ADDR;
        end else begin
            if ((state_reg == ST_WAIT) && (wait_cnt_reg != 16'd0))
                wait_cnt_reg <= wait_cnt_reg - 16'd1;
            if (state_reg == ST_READ)
                lat_cnt_reg <= LAT_LOAD;
            else if (state_reg == ST_LAT)
                lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
            if (cmp_en) begin
                idx_reg  <= idx_reg + CNT_W'(1);
                addr_reg <= addr_reg + ADDR_W'(STRIDE);
            end
        end
    end

    // Result counters; cleared on a new run, held across abort for debug.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            err_reg    <= '0;
            ok_reg     <= '0;
            fidx_reg   <= '0;
            fvalid_reg <= 1'b0;
        end else if (start_accept) begin
            err_reg    <= '0;
            ok_reg     <= '0;
            fidx_reg   <= '0;
            fvalid_reg <= 1'b0;
        end else if (cmp_en) begin
            if (word_match) begin
                ok_reg <= ok_reg + CNT_W'(1);
            end else begin
                err_reg <= err_reg + CNT_W'(1);
                if (!fvalid_reg) begin
                    fvalid_reg <= 1'b1;
                    fidx_reg   <= idx_reg;
                end
            end
        end
    end

    assign busy            = (state_reg == ST_WAIT) || (state_reg == ST_READ) ||
                             (state_reg == ST_LAT)  || (state_reg == ST_CMP);
    assign done            = (state_reg == ST_DONE);
    assign pass            = done && (err_reg == '0);
    assign mem_rd_en       = (state_reg == ST_READ);
    assign mem_addr        = addr_reg;
    assign err_count       = err_reg;
    assign ok_count        = ok_reg;
    assign first_err_idx   = fidx_reg;
    assign first_err_valid = fvalid_reg;

endmodule
